// File: rtl/branch_resolve.sv
// branch_resolve: tracks each fetch-stage beq prediction through ID and EX,
// checks it against the real outcome in EX, and on a mispredict redirects
// the PC, flushes the younger IF/ID instructions and trains the predictor.
//
// Optional build macro BR_STATS_EN enables the saturating resolve/mispredict
// counters; without it oBranch_cnt and oMispredict_cnt are tied to 0.
module branch_resolve #(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iStall,
    input  logic             iBranch_IF,
    input  logic             iPredTaken_IF,
    input  logic [PC_W-1:0]  iPC_IF,
    input  logic [PC_W-1:0]  iTarget_IF,
    input  logic             iBranch_regE,
    input  logic             izero_regE,
    output logic             oFlush,
    output logic             oRedirect_valid,
    output logic [PC_W-1:0]  oRedirect_pc,
    output logic             oUpdate_valid,
    output logic             oUpdate_taken,
    output logic             oUpdate_miss,
    output logic [CNT_W-1:0] oMispredict_cnt,
    output logic [CNT_W-1:0] oBranch_cnt
);

    typedef enum logic [0:0] {StNormal, StFlush} state_e;

    state_e          state_q;
    logic [2:0]      flush_cnt_q;

    // Slot D follows the instruction in ID, slot E the one in EX
    logic            d_valid_q;
    logic            d_pred_q;
    logic [PC_W-1:0] d_alt_q;
    logic            e_valid_q;
    logic            e_pred_q;
    logic [PC_W-1:0] e_alt_q;

    logic [PC_W-1:0] alt_pc_if;
    logic            resolve;
    logic            miss;

    // Alternate path, resolve and mispredict decode for the current cycle
    always_comb begin
        // Fall-through address wraps naturally modulo 2^PC_W
        alt_pc_if = iPredTaken_IF ? (iPC_IF + PC_W'(4)) : iTarget_IF;
        resolve   = (state_q == StNormal) && !iStall && e_valid_q && iBranch_regE;
        miss      = resolve && (izero_regE != e_pred_q);
    end

    // Control FSM, tracking slots and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StNormal;
            flush_cnt_q     <= 3'd0;
            d_valid_q       <= 1'b0;
            d_pred_q        <= 1'b0;
            d_alt_q         <= '0;
            e_valid_q       <= 1'b0;
            e_pred_q        <= 1'b0;
            e_alt_q         <= '0;
            oFlush          <= 1'b0;
            oRedirect_valid <= 1'b0;
            oRedirect_pc    <= '0;
            oUpdate_valid   <= 1'b0;
            oUpdate_taken   <= 1'b0;
            oUpdate_miss    <= 1'b0;
        end else begin
            oUpdate_valid   <= resolve;
            oRedirect_valid <= 1'b0;
            if (resolve) begin
                oUpdate_taken <= izero_regE;
                oUpdate_miss  <= miss;
            end
            unique case (state_q)
                StNormal: begin
                    if (miss) begin
                        oRedirect_valid <= 1'b1;
                        oRedirect_pc    <= e_alt_q;
                        oFlush          <= 1'b1;
                        state_q         <= StFlush;
                        flush_cnt_q     <= 3'(FLUSH_CYCLES - 1);
                        d_valid_q       <= 1'b0;
                        e_valid_q       <= 1'b0;
                    end else if (!iStall) begin
                        d_valid_q <= iBranch_IF;
                        d_pred_q  <= iPredTaken_IF;
                        d_alt_q   <= alt_pc_if;
                        e_valid_q <= d_valid_q;
                        e_pred_q  <= d_pred_q;
                        e_alt_q   <= d_alt_q;
                    end
                end
                StFlush: begin
                    // Flush length is fixed; a stall does not stretch it
                    if (flush_cnt_q == 3'd0) begin
                        oFlush  <= 1'b0;
                        state_q <= StNormal;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 3'd1;
                    end
                end
                default: state_q <= StNormal;
            endcase
        end
    end

`ifdef BR_STATS_EN
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mis_cnt_q;

    // Saturating statistics, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (resolve && (br_cnt_q != {CNT_W{1'b1}})) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (miss && (mis_cnt_q != {CNT_W{1'b1}})) begin
                mis_cnt_q <= mis_cnt_q + CNT_W'(1);
            end
        end
    end

    assign oBranch_cnt     = br_cnt_q;
    assign oMispredict_cnt = mis_cnt_q;
`else
    assign oBranch_cnt     = '0;
    assign oMispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus a random
// run checked against a queue-based reference model.
module tb_branch_resolve;

    localparam int unsigned PC_W = 32;
    localparam int unsigned FC   = 2;
    localparam int unsigned CW   = 2;
    localparam int          SAT  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            iStall, iBranch_IF, iPredTaken_IF, iBranch_regE, izero_regE;
    logic [PC_W-1:0] iPC_IF, iTarget_IF;
    logic            oFlush, oRedirect_valid, oUpdate_valid, oUpdate_taken, oUpdate_miss;
    logic [PC_W-1:0] oRedirect_pc;
    logic [CW-1:0]   oMispredict_cnt, oBranch_cnt;

    branch_resolve #(.PC_W(PC_W), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .iStall(iStall), .iBranch_IF(iBranch_IF),
        .iPredTaken_IF(iPredTaken_IF), .iPC_IF(iPC_IF), .iTarget_IF(iTarget_IF),
        .iBranch_regE(iBranch_regE), .izero_regE(izero_regE), .oFlush(oFlush),
        .oRedirect_valid(oRedirect_valid), .oRedirect_pc(oRedirect_pc),
        .oUpdate_valid(oUpdate_valid), .oUpdate_taken(oUpdate_taken),
        .oUpdate_miss(oUpdate_miss), .oMispredict_cnt(oMispredict_cnt),
        .oBranch_cnt(oBranch_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of in-flight predictions (front = youngest)
    typedef struct {
        logic            v;
        logic            p;
        logic [PC_W-1:0] alt;
    } slot_t;

    slot_t           trk[$];
    int              flush_left;
    logic            exp_uv, exp_ut, exp_um, exp_rv, exp_flush;
    logic [PC_W-1:0] exp_rpc;
    int              m_bcnt, m_mcnt;
    int              exp_bcnt, exp_mcnt;

    function automatic void empty_track();
        slot_t inv;
        inv.v = 1'b0; inv.p = 1'b0; inv.alt = '0;
        trk.delete();
        trk.push_back(inv);
        trk.push_back(inv);
    endfunction

    function automatic void model_reset();
        empty_track();
        flush_left = 0;
        exp_uv = 0; exp_ut = 0; exp_um = 0; exp_rv = 0; exp_flush = 0; exp_rpc = '0;
        m_bcnt = 0; m_mcnt = 0; exp_bcnt = 0; exp_mcnt = 0;
    endfunction

    // Predict the outputs after the coming edge from the current inputs
    function automatic void model_edge();
        slot_t old, nw;
        logic  res, mis;
        exp_uv = 0;
        exp_rv = 0;
        if (flush_left > 0) begin
            flush_left--;
        end else begin
            old = trk[trk.size()-1];
            res = !iStall && old.v && iBranch_regE;
            mis = res && (izero_regE != old.p);
            if (res) begin
                exp_uv = 1; exp_ut = izero_regE; exp_um = mis;
                if (m_bcnt < SAT) m_bcnt++;
                if (mis && m_mcnt < SAT) m_mcnt++;
            end
            if (mis) begin
                exp_rv = 1; exp_rpc = old.alt; flush_left = FC;
                empty_track();
            end else if (!iStall) begin
                nw.v = iBranch_IF; nw.p = iPredTaken_IF;
                nw.alt = iPredTaken_IF ? iPC_IF + 32'd4 : iTarget_IF;
                trk.push_front(nw);
                void'(trk.pop_back());
            end
        end
        exp_flush = (flush_left > 0);
`ifdef BR_STATS_EN
        exp_bcnt = m_bcnt; exp_mcnt = m_mcnt;
`else
        exp_bcnt = 0; exp_mcnt = 0;
`endif
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iStall = 0; iBranch_IF = 0; iPredTaken_IF = 0; iPC_IF = '0; iTarget_IF = '0;
        iBranch_regE = 0; izero_regE = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        model_reset();
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    // Fetch a beq, carry it to EX and resolve it; outputs are then visible
    task automatic run_beq(input logic [PC_W-1:0] pc, input logic pred,
                           input logic [PC_W-1:0] tgt, input logic zero);
        iBranch_IF = 1; iPredTaken_IF = pred; iPC_IF = pc; iTarget_IF = tgt;
        tick();
        idle_inputs();
        tick();
        iBranch_regE = 1; izero_regE = zero;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        model_reset();
        checks++;
        if ({oFlush, oRedirect_valid, oRedirect_pc, oUpdate_valid, oUpdate_taken,
             oUpdate_miss, oMispredict_cnt, oBranch_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: flush=%0b rv=%0b rpc=%h uv=%0b ut=%0b um=%0b mc=%0d bc=%0d, required all 0",
                     oFlush, oRedirect_valid, oRedirect_pc, oUpdate_valid, oUpdate_taken,
                     oUpdate_miss, oMispredict_cnt, oBranch_cnt);
        end
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_correct_not_taken();
        run_beq(32'h100, 1'b0, 32'h140, 1'b0);
        checks++;
        if ({oUpdate_valid, oUpdate_taken, oUpdate_miss, oFlush, oRedirect_valid} !== 5'b10000) begin
            failures++;
            $display("FAIL correct_nt: uv/ut/um/flush/rv=%b required 10000",
                     {oUpdate_valid, oUpdate_taken, oUpdate_miss, oFlush, oRedirect_valid});
        end
        tick();
        checks++;
        if ({oUpdate_valid, oFlush, oRedirect_valid} !== 3'b000) begin
            failures++;
            $display("FAIL correct_nt_after: uv/flush/rv=%b required 000",
                     {oUpdate_valid, oFlush, oRedirect_valid});
        end
    endtask

    task automatic test_mispredict_not_taken();
        int flush_cycles;
        run_beq(32'h100, 1'b0, 32'h140, 1'b1);
        checks++;
        if ({oRedirect_valid, oUpdate_valid, oUpdate_taken, oUpdate_miss, oFlush} !== 5'b11111 ||
            oRedirect_pc !== 32'h140) begin
            failures++;
            $display("FAIL miss_nt: rv/uv/ut/um/flush=%b rpc=%h required 11111 rpc=00000140",
                     {oRedirect_valid, oUpdate_valid, oUpdate_taken, oUpdate_miss, oFlush},
                     oRedirect_pc);
        end
        flush_cycles = 1;
        // A beq fetched during the flush must never resolve
        iBranch_IF = 1; iPC_IF = 32'h300; iTarget_IF = 32'h340; iBranch_regE = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            iBranch_IF = 0;
            if (oFlush) flush_cycles++;
            checks++;
            if (oUpdate_valid !== 1'b0 || oRedirect_valid !== 1'b0 || oFlush !== exp_flush) begin
                failures++;
                $display("FAIL miss_nt_flush[%0d]: uv=%0b rv=%0b flush=%0b required uv=0 rv=0 flush=%0b",
                         i, oUpdate_valid, oRedirect_valid, oFlush, exp_flush);
            end
        end
        checks++;
        if (flush_cycles != 2) begin
            failures++;
            $display("FAIL miss_nt_flush_len: got %0d cycles required 2", flush_cycles);
        end
        idle_inputs();
    endtask

    task automatic test_mispredict_taken();
        run_beq(32'h200, 1'b1, 32'h280, 1'b0);
        checks++;
        if (oRedirect_valid !== 1'b1 || oRedirect_pc !== 32'h204 || oUpdate_taken !== 1'b0 ||
            oUpdate_miss !== 1'b1) begin
            failures++;
            $display("FAIL miss_taken: rv=%0b rpc=%h ut=%0b um=%0b required rv=1 rpc=00000204 ut=0 um=1",
                     oRedirect_valid, oRedirect_pc, oUpdate_taken, oUpdate_miss);
        end
        tick();
        tick();
        run_beq(32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0);
        checks++;
        if (oRedirect_valid !== 1'b1 || oRedirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL miss_taken_wrap: rv=%0b rpc=%h required rv=1 rpc=00000000",
                     oRedirect_valid, oRedirect_pc);
        end
        tick();
        checks++;
        if (oRedirect_valid !== 1'b0 || oRedirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL redirect_hold: rv=%0b rpc=%h required rv=0 rpc=00000000",
                     oRedirect_valid, oRedirect_pc);
        end
        tick();
    endtask

    task automatic test_stall();
        int pulses;
        pulses = 0;
        iBranch_IF = 1; iPredTaken_IF = 1; iPC_IF = 32'h500; iTarget_IF = 32'h520;
        tick();
        idle_inputs();
        tick();
        iBranch_regE = 1; izero_regE = 1; iStall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (oUpdate_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: uv=%0b required 0", i, oUpdate_valid);
            end
        end
        iStall = 0;
        tick();
        checks++;
        if (oUpdate_valid !== 1'b1 || oUpdate_miss !== 1'b0 || oUpdate_taken !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: uv=%0b um=%0b ut=%0b required uv=1 um=0 ut=1",
                     oUpdate_valid, oUpdate_miss, oUpdate_taken);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (oUpdate_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL stall_single_pulse: extra pulses=%0d required 0", pulses);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_flush();
        run_beq(32'h600, 1'b0, 32'h700, 1'b1);
        tick();
        checks++;
        if (oFlush !== 1'b1) begin
            failures++;
            $display("FAIL midflush_pre: flush=%0b required 1", oFlush);
        end
        #1 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (oFlush !== 1'b0 || oRedirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL midflush_reset: flush=%0b rv=%0b required 0 0", oFlush, oRedirect_valid);
        end
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        run_beq(32'h800, 1'b1, 32'h900, 1'b1);
        checks++;
        if (oUpdate_valid !== 1'b1 || oUpdate_miss !== 1'b0 || oFlush !== 1'b0) begin
            failures++;
            $display("FAIL midflush_after: uv=%0b um=%0b flush=%0b required 1 0 0",
                     oUpdate_valid, oUpdate_miss, oFlush);
        end
        tick();
    endtask

    task automatic test_stats();
        int req;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_beq(32'h1000 + 32'(i * 16), 1'b0, 32'h2000, 1'b1);
            tick();
            tick();
        end
`ifdef BR_STATS_EN
        req = 3;
`else
        req = 0;
`endif
        checks++;
        if (int'(oMispredict_cnt) != req || int'(oBranch_cnt) != req) begin
            failures++;
            $display("FAIL stats_saturate: mc=%0d bc=%0d required %0d %0d",
                     oMispredict_cnt, oBranch_cnt, req, req);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            iStall        = ($urandom_range(0, 4) == 0);
            iBranch_IF    = $urandom_range(0, 1);
            iPredTaken_IF = $urandom_range(0, 1);
            iPC_IF        = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) iPC_IF = 32'hFFFF_FFFC;
            iTarget_IF    = $urandom() & 32'hFFFF_FFFC;
            iBranch_regE  = ($urandom_range(0, 9) < 7);
            izero_regE    = $urandom_range(0, 1);
            tick();
            checks++;
            if ({oFlush, oRedirect_valid, oUpdate_valid, oUpdate_taken, oUpdate_miss} !==
                {exp_flush, exp_rv, exp_uv, exp_ut, exp_um} || oRedirect_pc !== exp_rpc) begin
                failures++;
                $display("FAIL random[%0d]: flush/rv/uv/ut/um=%b rpc=%h required %b rpc=%h", i,
                         {oFlush, oRedirect_valid, oUpdate_valid, oUpdate_taken, oUpdate_miss},
                         oRedirect_pc, {exp_flush, exp_rv, exp_uv, exp_ut, exp_um}, exp_rpc);
            end
            checks++;
            if (int'(oBranch_cnt) != exp_bcnt || int'(oMispredict_cnt) != exp_mcnt) begin
                failures++;
                $display("FAIL random_cnt[%0d]: bc=%0d mc=%0d required %0d %0d", i,
                         oBranch_cnt, oMispredict_cnt, exp_bcnt, exp_mcnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1;
        idle_inputs();
        #2;
        test_reset();
        test_correct_not_taken();
        test_mispredict_not_taken();
        test_mispredict_taken();
        test_stall();
        test_reset_mid_flush();
        test_stats();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
